// File: rtl/board_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
// Shared defaults, width helpers, FSM state encodings and the metrics bundle
// for the board store / analyzer slice.
//   ROWS_DEF / COLS_DEF : default board geometry (20 x 10)
//   hw_of / sw_of       : height width and sum width for a given geometry
//   ST_*                : FSM state encodings (ST_CLEAR only reachable when
//                         BOARD_LINE_CLEAR_EN is defined)
//   metrics_t           : metric bundle sized for the default geometry
// ---------------------------------------------------------------------------
package board_pkg;

    localparam int ROWS_DEF = 20;
    localparam int COLS_DEF = 10;

    // Bits needed to hold a column height 0..rows.
    function automatic int hw_of(input int rows);
        return $clog2(rows + 1);
    endfunction

    // Bits needed to hold a whole-board sum 0..rows*cols.
    function automatic int sw_of(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SAVE  = 3'd1;
    localparam state_t ST_SCAN  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_CLEAR = 3'd4;

    localparam int HW_DEF = hw_of(ROWS_DEF);
    localparam int SW_DEF = sw_of(ROWS_DEF, COLS_DEF);

    typedef struct packed {
        logic [HW_DEF-1:0] max;
        logic [HW_DEF-1:0] rel;
        logic [SW_DEF-1:0] cum;
        logic [SW_DEF-1:0] rough;
        logic [SW_DEF-1:0] holes;
    } metrics_t;

endpackage

// File: rtl/board_store_analyzer_if.sv
// ---------------------------------------------------------------------------
// board_store_analyzer_if
// Request/response bus between the placement controller / move evaluator
// (master) and board_store_analyzer (slave).
//   req_save, req_analy : requests, held by the master until ready
//   row_idx, row_info   : target row and data for a save
//   ready               : slave idle; a request is taken on this edge
//   resp, err           : one-cycle completion pulse and save-range error
//   req_clear           : line-clear request (BOARD_LINE_CLEAR_EN only)
// ---------------------------------------------------------------------------
interface board_store_analyzer_if #(
    parameter int COLS = 10,
    parameter int IDXW = 6
);
    logic            req_save;
    logic            req_analy;
    logic [IDXW-1:0] row_idx;
    logic [COLS-1:0] row_info;
    logic            ready;
    logic            resp;
    logic            err;
`ifdef BOARD_LINE_CLEAR_EN
    logic            req_clear;

    modport master (output req_save, req_analy, row_idx, row_info, req_clear,
                    input  ready, resp, err);
    modport slave  (input  req_save, req_analy, row_idx, row_info, req_clear,
                    output ready, resp, err);
`else
    modport master (output req_save, req_analy, row_idx, row_info,
                    input  ready, resp, err);
    modport slave  (input  req_save, req_analy, row_idx, row_info,
                    output ready, resp, err);
`endif
endinterface

// File: rtl/column_profile.sv
// ---------------------------------------------------------------------------
// column_profile
// Combinational profile of one board column.
//   i_col    : ROWS bits, bit r = row r occupied (row 0 = bottom)
//   o_height : index of highest occupied row + 1, 0 for an empty column
//   o_holes  : empty cells below the column top
// ---------------------------------------------------------------------------
module column_profile
    import board_pkg::*;
#(
    parameter  int ROWS = ROWS_DEF,
    localparam int HW   = hw_of(ROWS)
) (
    input  logic [ROWS-1:0] i_col,
    output logic [HW-1:0]   o_height,
    output logic [HW-1:0]   o_holes
);

    logic [HW-1:0] w_ones;

    // Every occupied cell lies at or below the top, so holes = height - ones.
    always_comb begin
        o_height = '0;
        w_ones   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (i_col[r]) begin
                o_height = HW'(r + 1);
            end
            w_ones = w_ones + HW'(i_col[r]);
        end
        o_holes = o_height - w_ones;
    end

endmodule

// File: rtl/board_store_analyzer.sv
// ---------------------------------------------------------------------------
// board_store_analyzer
// Holds a ROWS x COLS occupancy board, accepts single-row saves and computes
// placement heuristics with a column-serial scan (one column per cycle).
// Optional line clear is compiled in with macro BOARD_LINE_CLEAR_EN.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : requests, row data, ready/resp/err handshake
//   board             : row r at [r*COLS +: COLS]
//   max_height, relative_height, cumulative_height, roughness, hole_count
//                     : metrics from the last completed scan
//   analy_valid       : metrics describe the current board
//   lines_cleared     : rows removed by the last clear (feature only)
// ---------------------------------------------------------------------------
module board_store_analyzer
    import board_pkg::*;
#(
    parameter  int ROWS = ROWS_DEF,
    parameter  int COLS = COLS_DEF,
    parameter  int IDXW = 6,
    localparam int HW   = hw_of(ROWS),
    localparam int SW   = sw_of(ROWS, COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    board_store_analyzer_if.slave  bus,
    output logic [ROWS*COLS-1:0]   board,
    output logic [HW-1:0]          max_height,
    output logic [HW-1:0]          relative_height,
    output logic [SW-1:0]          cumulative_height,
    output logic [SW-1:0]          roughness,
    output logic [SW-1:0]          hole_count,
    output logic                   analy_valid
`ifdef BOARD_LINE_CLEAR_EN
    ,
    output logic [HW-1:0]          lines_cleared
`endif
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t                     r_state;
    logic [ROWS-1:0][COLS-1:0]  r_board;
    logic [CW-1:0]              r_col;
    logic [HW-1:0]              r_acc_max, r_acc_min, r_h_prev;
    logic [SW-1:0]              r_acc_cum, r_acc_rough, r_acc_holes;
    logic [HW-1:0]              r_max, r_rel;
    logic [SW-1:0]              r_cum, r_rough, r_holes;
    logic                       r_resp, r_err, r_save_bad, r_valid;

    logic [ROWS-1:0]            w_col_bits;
    logic [HW-1:0]              w_h, w_holes;
    logic [HW:0]                w_diff;
    logic [HW-1:0]              w_absdiff;
    logic                       w_idle, w_idx_ok, w_acc_save, w_acc_analy;

    // Column currently being scanned, gathered across all rows.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_col
            assign w_col_bits[gi] = r_board[gi][r_col];
        end
    endgenerate

    column_profile #(.ROWS(ROWS)) u_profile (
        .i_col    (w_col_bits),
        .o_height (w_h),
        .o_holes  (w_holes)
    );

    // One extra bit carries the borrow so the sign of h - h_prev is known.
    assign w_diff    = {1'b0, w_h} - {1'b0, r_h_prev};
    assign w_absdiff = w_diff[HW] ? HW'(-w_diff) : w_diff[HW-1:0];

    assign w_idle     = (r_state == ST_IDLE);
    assign w_idx_ok   = (int'(bus.row_idx) < ROWS);
    assign w_acc_save = w_idle & bus.req_save;

`ifdef BOARD_LINE_CLEAR_EN
    logic                       w_acc_clear, w_rd_full;
    logic [COLS-1:0]            w_rd_row;
    logic [HW-1:0]              w_wr_final;
    logic [HW-1:0]              r_rd, r_wr, r_lines;

    assign w_acc_clear = w_idle & ~bus.req_save & bus.req_clear;
    assign w_acc_analy = w_idle & ~bus.req_save & ~bus.req_clear & bus.req_analy;

    always_comb begin
        w_rd_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_rd == HW'(r)) begin
                w_rd_row = r_board[r];
            end
        end
    end

    assign w_rd_full     = &w_rd_row;
    // Write pointer after this cycle's copy; used for the final zero fill.
    assign w_wr_final    = w_rd_full ? r_wr : r_wr + 1'b1;
    assign lines_cleared = r_lines;
`else
    assign w_acc_analy = w_idle & ~bus.req_save & bus.req_analy;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_board     <= '0;
            r_col       <= '0;
            r_acc_max   <= '0;
            r_acc_min   <= '0;
            r_h_prev    <= '0;
            r_acc_cum   <= '0;
            r_acc_rough <= '0;
            r_acc_holes <= '0;
            r_max       <= '0;
            r_rel       <= '0;
            r_cum       <= '0;
            r_rough     <= '0;
            r_holes     <= '0;
            r_resp      <= 1'b0;
            r_err       <= 1'b0;
            r_save_bad  <= 1'b0;
            r_valid     <= 1'b0;
`ifdef BOARD_LINE_CLEAR_EN
            r_rd        <= '0;
            r_wr        <= '0;
            r_lines     <= '0;
`endif
        end else begin
            r_resp <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_save) begin
                        // Out-of-range indices match no row, leaving the board intact.
                        for (int r = 0; r < ROWS; r++) begin
                            if (bus.row_idx == IDXW'(r)) begin
                                r_board[r] <= bus.row_info;
                            end
                        end
                        r_save_bad <= ~w_idx_ok;
                        r_state    <= ST_SAVE;
`ifdef BOARD_LINE_CLEAR_EN
                    end else if (w_acc_clear) begin
                        r_rd    <= '0;
                        r_wr    <= '0;
                        r_state <= ST_CLEAR;
`endif
                    end else if (w_acc_analy) begin
                        r_col       <= '0;
                        r_acc_max   <= '0;
                        r_acc_min   <= '0;
                        r_acc_cum   <= '0;
                        r_acc_rough <= '0;
                        r_acc_holes <= '0;
                        r_h_prev    <= '0;
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SAVE: begin
                    r_resp  <= 1'b1;
                    r_err   <= r_save_bad;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_SCAN: begin
                    if (r_col == '0) begin
                        // First column seeds max/min; roughness starts at column 1.
                        r_acc_max   <= w_h;
                        r_acc_min   <= w_h;
                        r_acc_cum   <= SW'(w_h);
                        r_acc_holes <= SW'(w_holes);
                        r_acc_rough <= '0;
                    end else begin
                        if (w_h > r_acc_max) r_acc_max <= w_h;
                        if (w_h < r_acc_min) r_acc_min <= w_h;
                        r_acc_cum   <= r_acc_cum + SW'(w_h);
                        r_acc_holes <= r_acc_holes + SW'(w_holes);
                        r_acc_rough <= r_acc_rough + SW'(w_absdiff);
                    end
                    r_h_prev <= w_h;
                    r_col    <= r_col + 1'b1;
                    if (r_col == CW'(COLS - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_max   <= r_acc_max;
                    r_rel   <= r_acc_max - r_acc_min;
                    r_cum   <= r_acc_cum;
                    r_rough <= r_acc_rough;
                    r_holes <= r_acc_holes;
                    r_valid <= 1'b1;
                    r_resp  <= 1'b1;
                    r_state <= ST_IDLE;
                end
`ifdef BOARD_LINE_CLEAR_EN
                ST_CLEAR: begin
                    // wr never passes rd, so copies only land on rows already read.
                    if (!w_rd_full) begin
                        for (int r = 0; r < ROWS; r++) begin
                            if (r_wr == HW'(r)) begin
                                r_board[r] <= w_rd_row;
                            end
                        end
                    end
                    r_rd <= r_rd + 1'b1;
                    r_wr <= w_wr_final;
                    if (r_rd == HW'(ROWS - 1)) begin
                        for (int r = 0; r < ROWS; r++) begin
                            if (HW'(r) >= w_wr_final) begin
                                r_board[r] <= '0;
                            end
                        end
                        r_lines <= HW'(ROWS) - w_wr_final;
                        r_resp  <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready         = w_idle;
    assign bus.resp          = r_resp;
    assign bus.err           = r_err;
    assign board             = r_board;
    assign max_height        = r_max;
    assign relative_height   = r_rel;
    assign cumulative_height = r_cum;
    assign roughness         = r_rough;
    assign hole_count        = r_holes;
    assign analy_valid       = r_valid;

endmodule

// File: doc/board_store_analyzer.md
Name: board_store_analyzer

Overview:
Parametrised successor to the row-save block of the board path. It holds a ROWS x COLS occupancy board, accepts single-row writes, and runs a column-serial analysis FSM. The FSM produces the heuristic metrics the AI/placement logic consumes: max/relative height, cumulative height, roughness and holes. It sits between the piece-placement controller (row writer) and the move evaluator (metric reader).

Parameters:
ROWS, 20, board height in rows; row 0 = bottom
COLS, 10, board width in columns; bit 0 of a row = leftmost column
IDXW, 6, width of row_idx (must satisfy 2^IDXW >= ROWS)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
req_save  in  1  row write request
req_analy  in  1  analysis request
row_idx  in  IDXW  target row for req_save
row_info  in  COLS  row data; bit c = column c occupied
ready  out  1  block idle, request accepted this cycle if asserted
resp  out  1  one-cycle completion pulse for the accepted request
err  out  1  one-cycle pulse with resp: save targeted row_idx >= ROWS
board  out  ROWS*COLS  row r at bits [r*COLS +: COLS]
max_height  out  HW  tallest column height
relative_height  out  HW  max minus min column height
cumulative_height  out  SW  sum of column heights
roughness  out  SW  sum of |h[c]-h[c+1]|, c = 0..COLS-2
hole_count  out  SW  empty cells below each column's top
analy_valid  out  1  metrics match current board; cleared by any write

Behaviour:
- Reset (rst_n=0 at posedge): board=0, all metrics 0, resp=0, err=0, analy_valid=0, ready=1, FSM=IDLE. Reset mid-SCAN aborts the scan and produces no resp.
- States: IDLE, SAVE, SCAN, DONE (plus CLEAR under the optional feature).
- ready=1 only in IDLE. Requests are sampled only when ready=1; requests while busy are ignored and the requester must hold them.
- req_save and req_analy asserted together: save wins; analy is not accepted that cycle.
- IDLE + req_save:
  - If row_idx < ROWS, the row is written at that edge. If row_idx >= ROWS, board is unchanged and err is pulsed.
  - FSM -> SAVE. In SAVE: resp=1 for one cycle, analy_valid<=0, then -> IDLE. Next request can be accepted 2 cycles after acceptance.
- IDLE + req_analy: column counter col<=0, accumulators cleared, FSM -> SCAN.
- SCAN, one column per cycle (COLS cycles):
  - h = index of highest set row + 1, or 0 if the column is empty.
  - holes += zeros in rows below h.
  - Accumulate cumulative height, max and min; for col>0 add |h - h_prev|.
  - col==COLS-1 -> DONE.
- DONE: metric outputs registered, analy_valid=1, resp=1 for one cycle, -> IDLE. resp rises COLS+1 cycles after the accepting edge.
- Metric outputs hold their values until the next DONE or reset.
- Widths: HW = clog2(ROWS+1), SW = clog2(ROWS*COLS+1). All accumulation is unsigned with no overflow by construction. Roughness uses an absolute difference in HW+1 bits.

Optional Feature:
Macro BOARD_LINE_CLEAR_EN.
- Defined:
  - Adds ports req_clear (in, 1) and lines_cleared (out, clog2(ROWS+1)).
  - Priority in IDLE is save > clear > analy.
  - CLEAR state runs for exactly ROWS cycles with read pointer rd and write pointer wr:
    - A full row (all COLS bits set) is skipped.
    - Otherwise row rd is copied to row wr and wr increments.
  - In the last cycle, rows >= final wr are zeroed. lines_cleared = ROWS - wr, resp pulses, analy_valid<=0.
- Undefined: no ports, no CLEAR state; board is modified only by req_save.

Decomposition:
- Package board_pkg: ROWS/COLS defaults, HW/SW width functions, FSM state enum, metrics struct (max, rel, cum, rough, holes).
- One sub-module: column_profile (combinational). Takes a ROWS-bit column and returns height and hole count. Instantiated once and muxed by col.

Test Plan:
1. Reset, then save row 0 = 10'h3FF, then analyze -> resp at cycle 11 after accept; max=1, rel=0, cum=10, rough=0, holes=0, analy_valid=1.
2. From reset, save row 2 = 10'h001, analyze -> max=3, rel=3, cum=3, rough=3, holes=2.
3. Save row_idx=25 with 10'h155 -> err=1 with resp, board unchanged, analy_valid unaffected only if it was already 0.
4. req_save and req_analy asserted together in IDLE -> row written, resp after 1 cycle, no scan; a held req_analy is then accepted 2 cycles after the save was accepted.
5. Start analyze, drop rst_n at SCAN cycle 4 -> no resp, all metrics 0, ready=1 the next cycle.
6. (BOARD_LINE_CLEAR_EN) row0=10'h3FF, row1=10'h001, req_clear -> after 20 cycles row0=10'h001, row1=0, lines_cleared=1, resp=1.
